// File: rtl/iter_lshift_pkg.sv
// Shared encodings for the iterative left-shift unit: operation select and FSM states.
package iter_lshift_pkg;

    typedef enum logic [1:0] {
        OP_LSL  = 2'b00,
        OP_ROL  = 2'b01,
        OP_SLO  = 2'b10,
        OP_PASS = 2'b11
    } shift_op_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_SHIFT = 2'b01,
        ST_DONE  = 2'b10
    } state_e;

endpackage

// File: rtl/iter_lshift.sv
// Multi-cycle left shifter (LSL/ROL/SLO/PASS), one bit per clock, start/busy/done handshake.
//
// state | meaning
// IDLE  | waiting for start; result/carry hold the last completed value
// SHIFT | one bit step per edge until the latched count runs out
// DONE  | one-cycle completion pulse, then back to IDLE
module iter_lshift
    import iter_lshift_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         CLK,
    input  logic         RESET,
    input  logic         start,
    input  logic [W-1:0] data,
    input  logic [W-1:0] shift_amt,
    input  logic [1:0]   shift_type,
    output logic [W-1:0] result,
    output logic         carry,
    output logic         busy,
    output logic         done
);

    localparam int CW = $clog2(W) + 1;
    localparam logic [W-1:0]  AMT_W = W'(W);
    localparam logic [CW-1:0] CNT_W = CW'(W);

    state_e         state_q, state_d;
    shift_op_e      op_q, op_d;
    logic [W-1:0]   result_q, result_d;
    logic           carry_q, carry_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [CW-1:0]  cnt_eff;
    shift_op_e      op_in;

    function automatic logic [W-1:0] step(input logic [W-1:0] v, input shift_op_e op);
        case (op)
            OP_LSL:  step = {v[W-2:0], 1'b0};
            OP_ROL:  step = {v[W-2:0], v[W-1]};
            OP_SLO:  step = {v[W-2:0], 1'b1};
            default: step = v;
        endcase
    endfunction

    assign op_in = shift_op_e'(shift_type);

    // Rotates wrap modulo W; plain shifts saturate at W since further steps change nothing new.
    always_comb begin
        cnt_eff = '0;
        case (op_in)
            OP_LSL, OP_SLO: cnt_eff = (shift_amt >= AMT_W) ? CNT_W : shift_amt[CW-1:0];
            OP_ROL:         cnt_eff = CW'(shift_amt[CW-2:0]);
            default:        cnt_eff = '0;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        result_d = result_q;
        carry_d  = carry_q;
        cnt_d    = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    result_d = data;
                    carry_d  = 1'b0;
                    op_d     = op_in;
                    cnt_d    = cnt_eff;
                    state_d  = (cnt_eff != '0) ? ST_SHIFT : ST_DONE;
                end
            end
            ST_SHIFT: begin
                carry_d  = result_q[W-1];
                result_d = step(result_q, op_q);
                cnt_d    = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) state_d = ST_DONE;
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q  <= ST_IDLE;
            op_q     <= OP_LSL;
            result_q <= '0;
            carry_q  <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            result_q <= result_d;
            carry_q  <= carry_d;
            cnt_q    <= cnt_d;
        end
    end

    assign result = result_q;
    assign carry  = carry_q;
    assign busy   = (state_q != ST_IDLE);
    assign done   = (state_q == ST_DONE);

endmodule

// File: tb/tb_iter_lshift.sv
// Directed bench for iter_lshift: vector table for single operations plus hand-built
// sequences for ignored restarts and mid-operation reset.
module tb_iter_lshift;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] data;
    logic [W-1:0] shift_amt;
    logic [1:0]   shift_type;
    logic [W-1:0] result;
    logic         carry;
    logic         busy;
    logic         done;

    int n_cmp = 0;
    int n_err = 0;

    iter_lshift #(.W(W)) dut (
        .CLK(clk), .RESET(rst), .start(start), .data(data),
        .shift_amt(shift_amt), .shift_type(shift_type),
        .result(result), .carry(carry), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] op;
        logic [7:0] din;
        logic [7:0] amt;
        logic [7:0] exp_res;
        logic       exp_c;
        int         exp_lat;
    } vec_t;

    vec_t vecs[15];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Called #1 after a rising edge; returns #1 after the edge following completion.
    task automatic run_op(input string name, input logic [1:0] op, input logic [7:0] din,
                          input logic [7:0] amt, input logic [7:0] exp_res, input logic exp_c,
                          input int exp_lat);
        int lat;
        int busy_bad;
        logic [7:0] res_s;
        logic c_s;
        lat = -1;
        busy_bad = 0;
        res_s = '0;
        c_s = 1'b0;
        start = 1'b1; data = din; shift_amt = amt; shift_type = op;
        @(posedge clk); #1;
        start = 1'b0;
        data = ~din; shift_amt = 8'd3; shift_type = ~op;
        for (int c = 1; c <= 300 && lat < 0; c++) begin
            @(negedge clk);
            if (!busy) busy_bad++;
            if (done) begin
                lat = c;
                res_s = result;
                c_s = carry;
            end
            @(posedge clk); #1;
        end
        if (lat < 0) begin
            n_cmp++; n_err++;
            $display("FAIL %s timeout: no done within 300 cycles", name);
        end else begin
            chk({name, " latency"}, lat, exp_lat);
            chk({name, " result"}, res_s, exp_res);
            chk({name, " carry"}, c_s, exp_c);
            chk({name, " busy gaps"}, busy_bad, 0);
            @(negedge clk);
            chk({name, " post busy"}, busy, 1'b0);
            chk({name, " post done"}, done, 1'b0);
            chk({name, " held result"}, result, exp_res);
            @(posedge clk); #1;
        end
    endtask

    initial begin
        int pulses;
        vecs[0]  = '{2'b00, 8'h81, 8'd3,   8'h08, 1'b0, 4};
        vecs[1]  = '{2'b01, 8'h81, 8'd1,   8'h03, 1'b1, 2};
        vecs[2]  = '{2'b01, 8'h81, 8'd9,   8'h03, 1'b1, 2};
        vecs[3]  = '{2'b00, 8'hFF, 8'd200, 8'h00, 1'b1, 9};
        vecs[4]  = '{2'b11, 8'h5A, 8'd7,   8'h5A, 1'b0, 1};
        vecs[5]  = '{2'b10, 8'h00, 8'd4,   8'h0F, 1'b0, 5};
        vecs[6]  = '{2'b00, 8'h5A, 8'd0,   8'h5A, 1'b0, 1};
        vecs[7]  = '{2'b10, 8'h00, 8'd8,   8'hFF, 1'b0, 9};
        vecs[8]  = '{2'b01, 8'h80, 8'd8,   8'h80, 1'b0, 1};
        vecs[9]  = '{2'b00, 8'h01, 8'd7,   8'h80, 1'b0, 8};
        vecs[10] = '{2'b10, 8'h80, 8'd255, 8'hFF, 1'b0, 9};
        vecs[11] = '{2'b00, 8'h03, 8'd8,   8'h00, 1'b1, 9};
        vecs[12] = '{2'b01, 8'hB4, 8'd3,   8'hA5, 1'b1, 4};
        vecs[13] = '{2'b10, 8'h01, 8'd2,   8'h07, 1'b0, 3};
        vecs[14] = '{2'b00, 8'hC0, 8'd1,   8'h80, 1'b1, 2};

        rst = 1'b1; start = 1'b0; data = 8'hA5; shift_amt = 8'd2; shift_type = 2'b00;
        #3;
        chk("reset result", result, 8'h00);
        chk("reset carry", carry, 1'b0);
        chk("reset busy", busy, 1'b0);
        chk("reset done", done, 1'b0);
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        chk("idle without start busy", busy, 1'b0);

        for (int i = 0; i < 15; i++)
            run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].din, vecs[i].amt,
                   vecs[i].exp_res, vecs[i].exp_c, vecs[i].exp_lat);

        // Restart attempts in SHIFT (cycle 2) and DONE (cycle 6) must be ignored.
        start = 1'b1; data = 8'h01; shift_amt = 8'd5; shift_type = 2'b01;
        @(posedge clk); #1;
        start = 1'b0;
        pulses = 0;
        for (int c = 1; c <= 10; c++) begin
            start = (c == 2 || c == 6);
            data = 8'hFF; shift_amt = 8'd1; shift_type = 2'b00;
            @(negedge clk);
            if (done) begin
                pulses++;
                chk("ignore done cycle", c, 6);
                chk("ignore result", result, 8'h20);
            end
            @(posedge clk); #1;
        end
        start = 1'b0;
        chk("ignore done pulses", pulses, 1);
        chk("ignore held result", result, 8'h20);
        chk("ignore idle busy", busy, 1'b0);

        // Reset in cycle 3 of LSL 0xF0 by 6.
        start = 1'b1; data = 8'hF0; shift_amt = 8'd6; shift_type = 2'b00;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("pre-reset busy", busy, 1'b1);
        rst = 1'b1;
        #2;
        chk("async reset result", result, 8'h00);
        chk("async reset busy", busy, 1'b0);
        chk("async reset done", done, 1'b0);
        chk("async reset carry", carry, 1'b0);
        @(posedge clk); #1;
        rst = 1'b0;
        pulses = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (done || busy) pulses++;
            @(posedge clk); #1;
        end
        chk("post-reset quiet", pulses, 0);
        run_op("after reset", 2'b00, 8'h01, 8'd1, 8'h02, 1'b0, 2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
